// File: rtl/mult_ctrl_rtl_if.sv
// mult_ctrl_rtl_if: command/status bundle between the shift-add multiplier controller and its datapath.
// Carries abort_i only when MULT_CTRL_ABORT_EN is defined.
interface mult_ctrl_rtl_if #(parameter int DP_WIDTH = 8) ();
  localparam int CW = $clog2(DP_WIDTH + 1);
  logic start_i;
  logic Q0_i;
  logic load_regs_ro;
  logic add_regs_ro;
  logic shift_regs_ro;
  logic ready_ro;
  logic done_ro;
  logic [CW-1:0] P_o;
`ifdef MULT_CTRL_ABORT_EN
  logic abort_i;
  modport slave (input start_i, Q0_i, abort_i, output load_regs_ro, add_regs_ro, shift_regs_ro, ready_ro, done_ro, P_o);
  modport master (output start_i, Q0_i, abort_i, input load_regs_ro, add_regs_ro, shift_regs_ro, ready_ro, done_ro, P_o);
`else
  modport slave (input start_i, Q0_i, output load_regs_ro, add_regs_ro, shift_regs_ro, ready_ro, done_ro, P_o);
  modport master (output start_i, Q0_i, input load_regs_ro, add_regs_ro, shift_regs_ro, ready_ro, done_ro, P_o);
`endif
endinterface

// File: rtl/mult_ctrl_rtl.sv
// mult_ctrl_rtl: shift-add multiplier controller, one add/shift pair per multiplier bit.
// Define MULT_CTRL_ABORT_EN to add abort_i, which returns a busy operation to idle.
module mult_ctrl_rtl #(
  parameter int DP_WIDTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_b_i,
  mult_ctrl_rtl_if.slave bus
);
  localparam int CW = $clog2(DP_WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ADD = 2'b01, S_SHIFT = 2'b11} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] p_q, p_d;
  logic abort_w;
`ifdef MULT_CTRL_ABORT_EN
  assign abort_w = bus.abort_i && state_q != S_IDLE;
`else
  assign abort_w = 1'b0;
`endif
  // encoding 2'b10 is unreachable; it falls through every decode to S_IDLE
  always_comb begin
    state_d = (state_q == S_IDLE)                  ? (bus.start_i ? S_ADD : S_IDLE) :
              (abort_w)                            ? S_IDLE :
              (state_q == S_ADD)                   ? S_SHIFT :
              (state_q == S_SHIFT && p_q != '0)    ? S_ADD : S_IDLE;
    p_d     = (state_q == S_IDLE && bus.start_i)   ? CW'(DP_WIDTH) :
              (abort_w)                            ? '0 :
              (state_q == S_ADD)                   ? p_q - CW'(1) : p_q;
  end
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q <= S_IDLE;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
    end
  end
  assign bus.ready_ro      = state_q == S_IDLE;
  assign bus.load_regs_ro  = state_q == S_IDLE && bus.start_i;
  assign bus.add_regs_ro   = state_q == S_ADD && bus.Q0_i && !abort_w;
  assign bus.shift_regs_ro = state_q == S_SHIFT && !abort_w;
  assign bus.done_ro       = bus.shift_regs_ro && p_q == '0;
  assign bus.P_o           = p_q;
endmodule

// File: doc/mult_ctrl_rtl.md
MULT_CTRL_RTL -- requirements
Module: mult_ctrl_rtl

Interface
REQ-001 Parameter: DP_WIDTH, default 8, datapath operand width in bits (legal range 2..32).
REQ-002 Derived width: CW = clog2(DP_WIDTH+1), width of the bit counter P.
REQ-003 Port clk_i, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 Port rst_b_i, input, 1, reset that is asynchronous and active-low.
REQ-005 Port start_i, input, 1, request to begin a multiply; sampled only in S_idle.
REQ-006 Port Q0_i, input, 1, LSB of the datapath multiplier register Q.
REQ-007 Port load_regs_ro, output, 1, datapath command: clear A and C, load B and Q.
REQ-008 Port add_regs_ro, output, 1, datapath command: {C,A} <= A + B.
REQ-009 Port shift_regs_ro, output, 1, datapath command: shift {C,A,Q} right one bit.
REQ-010 Port ready_ro, output, 1, high while the block is in S_idle.
REQ-011 Port done_ro, output, 1, one-cycle pulse marking the final shift of an operation.
REQ-012 Port P_o, output, CW, current counter value, for observation only.

Function
REQ-013 The block SHALL implement three states: S_idle=2'b00, S_add=2'b01 and S_shift=2'b11.
REQ-014 In S_idle, ready_ro SHALL be 1, and start_i=1 SHALL assert load_regs_ro, load P <= DP_WIDTH and move the block to S_add.
REQ-015 In S_idle with start_i=0, the block SHALL stay in S_idle, all commands SHALL be 0 and P SHALL hold its value.
REQ-016 In S_add, the block SHALL decrement P by 1, set add_regs_ro = Q0_i and move to S_shift unconditionally.
REQ-017 In S_shift, the block SHALL assert shift_regs_ro and then go to S_idle if P==0, otherwise to S_add.
REQ-018 done_ro SHALL equal (state==S_shift && P==0), a Mealy-free decode asserted in the same cycle as the final shift.
REQ-019 All command outputs SHALL be combinational decodes of state, start_i, Q0_i and P, each defaulting to 0.
REQ-020 Latency: from the load cycle to the done_ro cycle SHALL be exactly 2*DP_WIDTH cycles, and ready_ro SHALL return to 1 on the next cycle.
REQ-021 start_i in S_add or S_shift SHALL be ignored, with no queuing.
REQ-022 start_i held high SHALL start back-to-back operations separated by exactly one S_idle cycle, which is also the load cycle.
REQ-023 P SHALL never wrap: a decrement occurs only in S_add, where P >= 1.
REQ-024 Illegal state 2'b10 SHALL transition to S_idle on the next clock with all commands 0.

Reset
REQ-025 rst_b_i=0 SHALL immediately force state=S_idle and P=0, regardless of the clock.
REQ-026 While in reset, the outputs SHALL be: ready_ro=1, done_ro=0, add_regs_ro=0, shift_regs_ro=0, P_o=0, and load_regs_ro = start_i.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done_ro pulse.
REQ-028 After reset release, the first rising edge SHALL behave as S_idle.

Configuration
REQ-029 The macro MULT_CTRL_ABORT_EN SHALL, when defined, add the port abort_i (input, 1).
REQ-030 With MULT_CTRL_ABORT_EN defined, abort_i=1 in S_add or S_shift SHALL force the next state to S_idle and P <= 0, suppress add_regs_ro and shift_regs_ro in that cycle, and suppress done_ro.
REQ-031 With MULT_CTRL_ABORT_EN defined, abort_i SHALL be ignored in S_idle, and abort takes priority over start_i on the following idle cycle only by virtue of the state.
REQ-032 Without MULT_CTRL_ABORT_EN, the abort_i port and its logic SHALL be absent and behaviour SHALL be as in REQ-013..REQ-024.

Verification
REQ-033 Scenario: DP_WIDTH=8, Q=0x0B, B=0x17, single start pulse -> add_regs_ro high in add cycles 1, 2 and 4 only; done_ro 16 cycles after load; bench datapath {A,Q}=253.
REQ-034 Scenario: Q=0x00 -> add_regs_ro never asserted, 8 shift_regs_ro pulses, done_ro at cycle 16, product 0.
REQ-035 Scenario: start_i held high for 40 cycles -> loads at cycles 0, 17 and 34; each followed by done_ro at cycle +16.
REQ-036 Scenario: start_i pulsed at cycle 5 of a busy operation -> no extra load; P sequence unaffected.
REQ-037 Scenario: rst_b_i dropped mid-clock at cycle 7 -> state=S_idle and P_o=0 immediately, no done_ro, ready_ro=1.
REQ-038 Scenario (MULT_CTRL_ABORT_EN): abort_i=1 in cycle 6 -> S_idle next cycle, P_o=0, no done_ro, and a new start is accepted afterwards.
